// File: rtl/ag_tcu_step_sched_pkg.sv
// Shared types for the AG-TCU step scheduler: FSM states, request and micro-op records.
package ag_tcu_sched_pkg;

    localparam int UUID_W = 44;
    localparam int WID_W  = 2;
    localparam int RD_W   = 6;
    localparam int STEP_W = 4;
    localparam int FMT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Latched MMA request; steps_* are counts minus one.
    typedef struct packed {
        logic [UUID_W-1:0] uuid;
        logic [WID_W-1:0]  wid;
        logic [RD_W-1:0]   rd;
        logic [FMT_W-1:0]  fmt_s;
        logic [FMT_W-1:0]  fmt_d;
        logic [STEP_W-1:0] steps_m;
        logic [STEP_W-1:0] steps_n;
    } req_t;

    // One per-step micro-op presented to the FEDP unit.
    typedef struct packed {
        logic [STEP_W-1:0] step_m;
        logic [STEP_W-1:0] step_n;
        logic [RD_W-1:0]   rd;
        logic [UUID_W-1:0] uuid;
        logic [WID_W-1:0]  wid;
        logic [FMT_W-1:0]  fmt_s;
        logic [FMT_W-1:0]  fmt_d;
    } uop_t;

    // Destination register of step (m, n): row-major offset from the base, wrapping mod 2^RD_W.
    function automatic logic [RD_W-1:0] step_rd(
        input logic [RD_W-1:0]   base,
        input logic [STEP_W-1:0] m,
        input logic [STEP_W-1:0] n,
        input logic [STEP_W-1:0] steps_n
    );
        logic [8:0] lin;
        lin = ({5'b0, m} * ({5'b0, steps_n} + 9'd1)) + {5'b0, n};
        return base + lin[RD_W-1:0];
    endfunction

endpackage

// File: rtl/ag_tcu_step_sched_if.sv
// Request / micro-op / completion / done bundle between dispatch, scheduler and FEDP.
interface ag_tcu_step_sched_if;
    import ag_tcu_sched_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [UUID_W-1:0] req_uuid;
    logic [WID_W-1:0]  req_wid;
    logic [RD_W-1:0]   req_rd;
    logic [FMT_W-1:0]  req_fmt_s;
    logic [FMT_W-1:0]  req_fmt_d;
    logic [STEP_W-1:0] req_steps_m;
    logic [STEP_W-1:0] req_steps_n;

    logic              uop_valid;
    logic              uop_ready;
    logic [STEP_W-1:0] uop_step_m;
    logic [STEP_W-1:0] uop_step_n;
    logic [RD_W-1:0]   uop_rd;
    logic [UUID_W-1:0] uop_uuid;
    logic [WID_W-1:0]  uop_wid;
    logic [FMT_W-1:0]  uop_fmt_s;
    logic [FMT_W-1:0]  uop_fmt_d;

    logic              cmp_valid;

    logic              done_valid;
    logic              done_ready;
    logic [UUID_W-1:0] done_uuid;
    logic [WID_W-1:0]  done_wid;

    logic              busy;
    logic              cmp_err;

    modport slave (
        input  req_valid, req_uuid, req_wid, req_rd, req_fmt_s, req_fmt_d,
               req_steps_m, req_steps_n, uop_ready, cmp_valid, done_ready,
        output req_ready, uop_valid, uop_step_m, uop_step_n, uop_rd, uop_uuid,
               uop_wid, uop_fmt_s, uop_fmt_d, done_valid, done_uuid, done_wid,
               busy, cmp_err
    );

    modport master (
        output req_valid, req_uuid, req_wid, req_rd, req_fmt_s, req_fmt_d,
               req_steps_m, req_steps_n, uop_ready, cmp_valid, done_ready,
        input  req_ready, uop_valid, uop_step_m, uop_step_n, uop_rd, uop_uuid,
               uop_wid, uop_fmt_s, uop_fmt_d, done_valid, done_uuid, done_wid,
               busy, cmp_err
    );

endinterface

// File: rtl/ag_tcu_credit_cnt.sv
// Outstanding micro-op counter: up on issue, down on completion, with credit and underflow flags.
module ag_tcu_credit_cnt #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,        // new instruction: start from zero
    input  logic inc_i,        // micro-op fired
    input  logic dec_req_i,    // completion pulse seen
    input  logic dec_allow_i,  // completions are legal in the current phase
    output logic has_credit_o,
    output logic is_zero_o,
    output logic is_one_o,
    output logic underflow_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_ok;

    // A completion only counts when expected and something is actually in flight.
    assign dec_ok       = dec_req_i && dec_allow_i && (cnt_q != '0);
    assign underflow_o  = dec_req_i && !dec_ok;
    assign has_credit_o = (cnt_q < CW'(MAX_OUTSTANDING));
    assign is_zero_o    = (cnt_q == '0);
    assign is_one_o     = (cnt_q == CW'(1));

    // Next count; simultaneous issue and completion leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!inc_i && dec_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ag_tcu_step_sched.sv
// Expands one MMA request into (m, n) micro-ops under a credit limit and retires it with a done token.
module ag_tcu_step_sched
    import ag_tcu_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic reset,
    ag_tcu_step_sched_if.slave bus
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [STEP_W-1:0] m_q, m_d;
    logic [STEP_W-1:0] n_q, n_d;
    logic              cmp_err_q, cmp_err_d;

    logic has_credit, cnt_zero, cnt_one, underflow;
    logic req_fire, uop_fire, done_fire, last_step, uop_valid_w, dec_allow;
    uop_t uop;

    assign req_fire    = (state_q == IDLE) && bus.req_valid;
    assign uop_valid_w = (state_q == ISSUE) && has_credit;
    assign uop_fire    = uop_valid_w && bus.uop_ready;
    assign done_fire   = (state_q == DONE) && bus.done_ready;
    assign last_step   = (m_q == req_q.steps_m) && (n_q == req_q.steps_n);
    assign dec_allow   = (state_q == ISSUE) || (state_q == DRAIN);

    ag_tcu_credit_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (req_fire),
        .inc_i       (uop_fire),
        .dec_req_i   (bus.cmp_valid),
        .dec_allow_i (dec_allow),
        .has_credit_o(has_credit),
        .is_zero_o   (cnt_zero),
        .is_one_o    (cnt_one),
        .underflow_o (underflow)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DRAIN exits once the last in-flight op completes (or none are left).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_fire) state_d = ISSUE;
            ISSUE: if (uop_fire && last_step) state_d = DRAIN;
            DRAIN: if (cnt_zero || (cnt_one && bus.cmp_valid)) state_d = DONE;
            DONE:  if (done_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.uop_valid  = uop_valid_w;
        bus.done_valid = (state_q == DONE);
        bus.busy       = (state_q != IDLE);
    end

    // Request latch and step indices; n is the inner loop.
    always_comb begin
        req_d     = req_q;
        m_d       = m_q;
        n_d       = n_q;
        cmp_err_d = cmp_err_q | underflow;
        if (req_fire) begin
            req_d.uuid    = bus.req_uuid;
            req_d.wid     = bus.req_wid;
            req_d.rd      = bus.req_rd;
            req_d.fmt_s   = bus.req_fmt_s;
            req_d.fmt_d   = bus.req_fmt_d;
            req_d.steps_m = bus.req_steps_m;
            req_d.steps_n = bus.req_steps_n;
            m_d           = '0;
            n_d           = '0;
        end else if (uop_fire) begin
            if (n_q == req_q.steps_n) begin
                n_d = '0;
                m_d = m_q + STEP_W'(1);
            end else begin
                n_d = n_q + STEP_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= '0;
            m_q       <= '0;
            n_q       <= '0;
            cmp_err_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            m_q       <= m_d;
            n_q       <= n_d;
            cmp_err_q <= cmp_err_d;
        end
    end

    // Micro-op payload from the latched request and current indices.
    always_comb begin
        uop.step_m = m_q;
        uop.step_n = n_q;
        uop.rd     = step_rd(req_q.rd, m_q, n_q, req_q.steps_n);
        uop.uuid   = req_q.uuid;
        uop.wid    = req_q.wid;
        uop.fmt_s  = req_q.fmt_s;
        uop.fmt_d  = req_q.fmt_d;
    end

    assign bus.uop_step_m = uop.step_m;
    assign bus.uop_step_n = uop.step_n;
    assign bus.uop_rd     = uop.rd;
    assign bus.uop_uuid   = uop.uuid;
    assign bus.uop_wid    = uop.wid;
    assign bus.uop_fmt_s  = uop.fmt_s;
    assign bus.uop_fmt_d  = uop.fmt_d;
    assign bus.done_uuid  = req_q.uuid;
    assign bus.done_wid   = req_q.wid;
    assign bus.cmp_err    = cmp_err_q;

endmodule

// File: tb/tb_ag_tcu_step_sched.sv
// Scoreboard bench: stimulus pushes expected micro-ops/done tokens, negedge monitors pop and compare.
module tb_ag_tcu_step_sched;
    import ag_tcu_sched_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ag_tcu_step_sched_if if4 ();
    ag_tcu_step_sched_if if2 ();

    ag_tcu_step_sched #(.MAX_OUTSTANDING(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
    ag_tcu_step_sched #(.MAX_OUTSTANDING(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct packed {
        logic [3:0]  m;
        logic [3:0]  n;
        logic [5:0]  rd;
        logic [43:0] uuid;
    } exp_t;

    exp_t        q4[$];
    exp_t        q2[$];
    logic [43:0] d4[$];
    logic [43:0] d2[$];

    // completion generation for the MAX=4 instance
    logic        cmp_man4 = 1'b0;
    logic        auto4 = 1'b0;
    int          lat4 = 1;
    logic [15:0] pipe4 = '0;
    logic        fire4_n = 1'b0;
    logic        cmp_auto4;
    exp_t        saved4;
    logic        stall4 = 1'b0;

    // model of the MAX=2 instance's outstanding count
    int fires2 = 0, cmps2 = 0, out2 = 0, viol2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] m, input logic [3:0] n,
                                input logic [5:0] rd, input logic [43:0] u);
        exp_t e;
        e.m = m; e.n = n; e.rd = rd; e.uuid = u;
        return e;
    endfunction

    assign cmp_auto4     = pipe4[lat4-1];
    assign if4.cmp_valid = cmp_man4 | cmp_auto4;

    always @(posedge clk) pipe4 <= {pipe4[14:0], fire4_n & auto4};

    // Monitor for the MAX=4 instance.
    always @(negedge clk) begin
        exp_t cur;
        cur.m = if4.uop_step_m; cur.n = if4.uop_step_n;
        cur.rd = if4.uop_rd; cur.uuid = if4.uop_uuid;
        fire4_n = if4.uop_valid && if4.uop_ready;
        if (stall4 && if4.uop_valid) chk("uop4_stable", 64'(cur), 64'(saved4));
        stall4 = if4.uop_valid && !if4.uop_ready;
        saved4 = cur;
        if (fire4_n) begin
            if (q4.size() == 0) chk("uop4_unexpected", 64'(cur), 64'h0);
            else chk("uop4_payload", 64'(cur), 64'(q4.pop_front()));
            $display("uop4 m=%0d n=%0d rd=%0d uuid=%0h", cur.m, cur.n, cur.rd, cur.uuid);
        end
        if (if4.done_valid && if4.done_ready) begin
            if (d4.size() == 0) chk("done4_unexpected", 64'(if4.done_uuid), 64'h0);
            else chk("done4_uuid", 64'(if4.done_uuid), 64'(d4.pop_front()));
            $display("done4 uuid=%0h", if4.done_uuid);
        end
    end

    // Monitor for the MAX=2 instance, with a credit-window model.
    always @(negedge clk) begin
        exp_t cur;
        logic f;
        cur.m = if2.uop_step_m; cur.n = if2.uop_step_n;
        cur.rd = if2.uop_rd; cur.uuid = if2.uop_uuid;
        f = if2.uop_valid && if2.uop_ready;
        if (out2 >= 2 && if2.uop_valid) viol2++;
        if (f) begin
            fires2++;
            if (q2.size() == 0) chk("uop2_unexpected", 64'(cur), 64'h0);
            else chk("uop2_payload", 64'(cur), 64'(q2.pop_front()));
            $display("uop2 m=%0d n=%0d rd=%0d uuid=%0h", cur.m, cur.n, cur.rd, cur.uuid);
        end
        if (if2.cmp_valid) cmps2++;
        out2 = out2 + (f ? 1 : 0) - (if2.cmp_valid ? 1 : 0);
        if (if2.done_valid && if2.done_ready) begin
            if (d2.size() == 0) chk("done2_unexpected", 64'(if2.done_uuid), 64'h0);
            else chk("done2_uuid", 64'(if2.done_uuid), 64'(d2.pop_front()));
            $display("done2 uuid=%0h", if2.done_uuid);
        end
    end

    task automatic send4(input logic [43:0] uuid, input logic [5:0] rd,
                         input logic [3:0] sm, input logic [3:0] sn);
        chk("req4_ready", 64'(if4.req_ready), 64'h1);
        if4.req_valid = 1'b1; if4.req_uuid = uuid; if4.req_wid = 2'd1; if4.req_rd = rd;
        if4.req_fmt_s = 3'd2; if4.req_fmt_d = 3'd5;
        if4.req_steps_m = sm; if4.req_steps_n = sn;
        @(posedge clk); #1;
        if4.req_valid = 1'b0;
    endtask

    task automatic wait_done4(input int limit, output int waited);
        waited = -1;
        for (int i = 0; i < limit; i++) begin
            if (if4.done_valid) begin
                waited = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_done;
        int w;
        if4.req_valid = 0; if4.req_uuid = '0; if4.req_wid = '0; if4.req_rd = '0;
        if4.req_fmt_s = '0; if4.req_fmt_d = '0; if4.req_steps_m = '0; if4.req_steps_n = '0;
        if4.uop_ready = 1; if4.done_ready = 1;
        if2.req_valid = 0; if2.req_uuid = '0; if2.req_wid = '0; if2.req_rd = '0;
        if2.req_fmt_s = '0; if2.req_fmt_d = '0; if2.req_steps_m = '0; if2.req_steps_n = '0;
        if2.uop_ready = 1; if2.done_ready = 1; if2.cmp_valid = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        chk("rst_req_ready", 64'(if4.req_ready), 64'h1);
        chk("rst_uop_valid", 64'(if4.uop_valid), 64'h0);
        chk("rst_done_valid", 64'(if4.done_valid), 64'h0);
        chk("rst_busy", 64'(if4.busy), 64'h0);
        chk("rst_cmp_err", 64'(if4.cmp_err), 64'h0);

        // 1x1, rd 8, completion 5 cycles after issue: done in the 7th cycle after req fire
        q4.push_back(mk(4'd0, 4'd0, 6'd8, 44'h111));
        d4.push_back(44'h111);
        send4(44'h111, 6'd8, 4'd0, 4'd0);
        chk("t1_first_valid", 64'(if4.uop_valid), 64'h1);
        chk("t1_fmt_wid", 64'({if4.uop_fmt_s, if4.uop_fmt_d, if4.uop_wid}), 64'({3'd2, 3'd5, 2'd1}));
        k_done = -1;
        for (int k = 1; k <= 12; k++) begin
            if (if4.done_valid) begin
                k_done = k;
                break;
            end
            cmp_man4 = (k == 6);
            @(posedge clk); #1;
        end
        cmp_man4 = 1'b0;
        chk("t1_done_latency", 64'(k_done), 64'd7);
        @(posedge clk); #1;
        chk("t1_req_ready_after", 64'(if4.req_ready), 64'h1);
        chk("t1_cmp_err", 64'(if4.cmp_err), 64'h0);

        // 2x2, rd 10, no completions: 4 back-to-back uops, then parked in DRAIN
        q4.push_back(mk(4'd0, 4'd0, 6'd10, 44'h222));
        q4.push_back(mk(4'd0, 4'd1, 6'd11, 44'h222));
        q4.push_back(mk(4'd1, 4'd0, 6'd12, 44'h222));
        q4.push_back(mk(4'd1, 4'd1, 6'd13, 44'h222));
        send4(44'h222, 6'd10, 4'd1, 4'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("t2_uop_valid_run", 64'(if4.uop_valid), 64'h1);
            @(posedge clk); #1;
        end
        chk("t2_uop_valid_after", 64'(if4.uop_valid), 64'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_drain_busy", 64'(if4.busy), 64'h1);
        chk("t2_drain_no_done", 64'(if4.done_valid), 64'h0);
        d4.push_back(44'h222);
        cmp_man4 = 1'b1;
        repeat (4) @(posedge clk);
        #1 cmp_man4 = 1'b0;
        wait_done4(5, w);
        chk("t2_done_seen", 64'(w), 64'd0);
        @(posedge clk); #1;

        // backpressure: 2x3 at rd 60 wraps past 63; uop_ready toggles
        q4.push_back(mk(4'd0, 4'd0, 6'd60, 44'h555));
        q4.push_back(mk(4'd0, 4'd1, 6'd61, 44'h555));
        q4.push_back(mk(4'd0, 4'd2, 6'd62, 44'h555));
        q4.push_back(mk(4'd1, 4'd0, 6'd63, 44'h555));
        q4.push_back(mk(4'd1, 4'd1, 6'd0, 44'h555));
        q4.push_back(mk(4'd1, 4'd2, 6'd1, 44'h555));
        d4.push_back(44'h555);
        auto4 = 1'b1; lat4 = 3;
        send4(44'h555, 6'd60, 4'd1, 4'd2);
        k_done = -1;
        for (int k = 0; k < 60; k++) begin
            if (if4.done_valid) begin
                k_done = k;
                break;
            end
            if4.uop_ready = k[0];
            @(posedge clk); #1;
        end
        if4.uop_ready = 1'b1;
        chk("t5_done_seen", 64'(k_done >= 0), 64'h1);
        @(posedge clk); #1;
        chk("t5_cmp_err", 64'(if4.cmp_err), 64'h0);

        // done_ready held low: done token and uuid held, req_ready low until after fire
        q4.push_back(mk(4'd0, 4'd0, 6'd33, 44'h666));
        d4.push_back(44'h666);
        if4.done_ready = 1'b0; lat4 = 2;
        send4(44'h666, 6'd33, 4'd0, 4'd0);
        wait_done4(20, w);
        chk("t6_done_seen", 64'(w >= 0), 64'h1);
        for (int i = 0; i < 5; i++) begin
            chk("t6_done_hold", 64'(if4.done_valid), 64'h1);
            chk("t6_uuid_hold", 64'(if4.done_uuid), 64'h666);
            chk("t6_req_ready_low", 64'(if4.req_ready), 64'h0);
            @(posedge clk); #1;
        end
        if4.done_ready = 1'b1;
        chk("t6_req_ready_fire", 64'(if4.req_ready), 64'h0);
        @(posedge clk); #1;
        chk("t6_req_ready_after", 64'(if4.req_ready), 64'h1);
        auto4 = 1'b0;

        // 4x4 on the MAX=2 instance with a completion every 3rd cycle
        for (int i = 0; i < 16; i++) q2.push_back(mk(4'(i / 4), 4'(i % 4), 6'(i), 44'h333));
        d2.push_back(44'h333);
        if2.req_valid = 1'b1; if2.req_uuid = 44'h333; if2.req_wid = 2'd2; if2.req_rd = 6'd0;
        if2.req_steps_m = 4'd3; if2.req_steps_n = 4'd3;
        @(posedge clk); #1;
        if2.req_valid = 1'b0;
        k_done = -1;
        for (int k = 1; k < 200; k++) begin
            if (if2.done_valid) begin
                k_done = k;
                break;
            end
            if2.cmp_valid = ((k % 3) == 0) && (out2 > 0);
            @(posedge clk); #1;
        end
        if2.cmp_valid = 1'b0;
        chk("t3_done_seen", 64'(k_done >= 0), 64'h1);
        chk("t3_cmps_at_done", 64'(cmps2), 64'd16);
        chk("t3_uop_count", 64'(fires2), 64'd16);
        chk("t3_credit_violations", 64'(viol2), 64'd0);
        chk("t3_cmp_err", 64'(if2.cmp_err), 64'h0);
        @(posedge clk); #1;

        // spurious completion in IDLE is sticky
        chk("t7_err_before", 64'(if4.cmp_err), 64'h0);
        cmp_man4 = 1'b1;
        @(posedge clk); #1;
        cmp_man4 = 1'b0;
        chk("t7_err_set", 64'(if4.cmp_err), 64'h1);
        chk("t7_idle", 64'(if4.busy), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("t7_err_sticky", 64'(if4.cmp_err), 64'h1);

        // reset while issuing an 8-step request
        if4.uop_ready = 1'b0;
        send4(44'h777, 6'd20, 4'd0, 4'd7);
        chk("t8_issuing", 64'({if4.busy, if4.uop_valid}), 64'h3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t8_req_ready", 64'(if4.req_ready), 64'h1);
        chk("t8_outputs_low", 64'({if4.uop_valid, if4.done_valid, if4.busy, if4.cmp_err}), 64'h0);
        chk("t8_indices", 64'({if4.uop_step_m, if4.uop_step_n}), 64'h0);
        if4.uop_ready = 1'b1;
        @(posedge clk); #1;

        chk("end_q4_empty", 64'(q4.size() + d4.size()), 64'd0);
        chk("end_q2_empty", 64'(q2.size() + d2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
